// File: rtl/reg_file_read_np_if.sv
// Register-file access bundle: one write port plus NUM_READ read request/response ports.
// Latency: none (wires only); read responses arrive one cycle after the request.
// Backpressure: none; every request issued is completed.
interface reg_file_read_np_if #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                               wr_en;
  logic [AW-1:0]                      wr_addr;
  logic [WIDTH-1:0]                   wr_data;
  logic [NUM_READ-1:0]                rd_en;
  logic [NUM_READ-1:0][AW-1:0]        rd_addr;
  logic [NUM_READ-1:0][WIDTH-1:0]     rd_data;
  logic [NUM_READ-1:0]                rd_valid;

  // Requester side (decode stage control).
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/reg_file_read_np.sv
// Parametrised register file: NUM_READ registered read ports, one write port, bypass, optional hard-zero reg.
// Latency: exactly 1 cycle from rd_addr/rd_en to rd_data/rd_valid on every port.
// Backpressure: none; reads and writes are accepted every cycle.
module reg_file_read_np #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  reg_file_read_np_if.slave        rf
);
  localparam int AW = $clog2(DEPTH);

  // Sized copies of the integer parameters so address compares stay width-exact.
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_ZREG  = AW'(ZERO_REG);
  localparam bit            LP_ZEN   = (ZERO_EN != 0);

  logic [WIDTH-1:0]                r_mem [DEPTH];
  logic [NUM_READ-1:0][WIDTH-1:0]  r_rd_data;
  logic [NUM_READ-1:0]             r_rd_valid;

  logic                            w_wr_in_range;
  logic                            w_wr_is_zero;
  logic                            w_wr_ok;
  logic [NUM_READ-1:0][WIDTH-1:0]  w_rd_val;

  // Writes to out-of-range indices or to the hard-zero register are dropped,
  // so storage is never indexed with an address it does not hold.
  assign w_wr_in_range = ({1'b0, rf.wr_addr} < LP_DEPTH);
  assign w_wr_is_zero  = LP_ZEN && (rf.wr_addr == LP_ZREG);
  assign w_wr_ok       = rf.wr_en && w_wr_in_range && !w_wr_is_zero;

  // Storage update: async clear of every entry, single write per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Per-port read value: hard-zero, then range guard, then same-cycle bypass, then storage.
  always_comb begin
    w_rd_val = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (LP_ZEN && (rf.rd_addr[p] == LP_ZREG)) begin
        w_rd_val[p] = '0;
      end else if ({1'b0, rf.rd_addr[p]} >= LP_DEPTH) begin
        w_rd_val[p] = '0;
      end else if (rf.wr_en && (rf.wr_addr == rf.rd_addr[p])) begin
        w_rd_val[p] = rf.wr_data;
      end else begin
        w_rd_val[p] = r_mem[rf.rd_addr[p]];
      end
    end
  end

  // Output registers: load on request, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_READ; p++) begin
        r_rd_valid[p] <= rf.rd_en[p];
        if (rf.rd_en[p]) begin
          r_rd_data[p] <= w_rd_val[p];
        end
      end
    end
  end

  assign rf.rd_data  = r_rd_data;
  assign rf.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_reg_file_read_np.sv
// Bench for reg_file_read_np: three instances (default, ZERO_EN=0, DEPTH=24/NUM_READ=3).
// Stimulus pushes expected per-port valid/data after each edge; a negedge monitor pops and compares.
// Outputs are sampled on the falling edge, inputs driven 1 time unit after the rising edge.
module tb_reg_file_read_np;

  typedef struct packed {
    logic [2:0]        vld;
    logic [2:0][63:0]  dat;
  } exp_t;

  logic clk;
  logic reset_n;

  reg_file_read_np_if #(.WIDTH(64), .DEPTH(32), .NUM_READ(2)) ifa ();
  reg_file_read_np_if #(.WIDTH(64), .DEPTH(32), .NUM_READ(2)) ifb ();
  reg_file_read_np_if #(.WIDTH(64), .DEPTH(24), .NUM_READ(3)) ifc ();

  reg_file_read_np #(.WIDTH(64), .DEPTH(32), .NUM_READ(2), .ZERO_EN(1), .ZERO_REG(31))
    dut_a (.clk(clk), .reset_n(reset_n), .rf(ifa));
  reg_file_read_np #(.WIDTH(64), .DEPTH(32), .NUM_READ(2), .ZERO_EN(0), .ZERO_REG(31))
    dut_b (.clk(clk), .reset_n(reset_n), .rf(ifb));
  reg_file_read_np #(.WIDTH(64), .DEPTH(24), .NUM_READ(3), .ZERO_EN(1), .ZERO_REG(31))
    dut_c (.clk(clk), .reset_n(reset_n), .rf(ifc));

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        qc[$];
  logic [63:0] hold [3][3];
  int          n_chk  = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per DUT per clock edge, compared on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("A p%0d valid", p), 64'(ifa.rd_valid[p]), 64'(e.vld[p]));
        chk($sformatf("A p%0d data", p), ifa.rd_data[p], e.dat[p]);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("B p%0d valid", p), 64'(ifb.rd_valid[p]), 64'(e.vld[p]));
        chk($sformatf("B p%0d data", p), ifb.rd_data[p], e.dat[p]);
      end
    end
    if (qc.size() != 0) begin
      e = qc.pop_front();
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("C p%0d valid", p), 64'(ifc.rd_valid[p]), 64'(e.vld[p]));
        chk($sformatf("C p%0d data", p), ifc.rd_data[p], e.dat[p]);
      end
    end
  end

  task automatic drive_idle();
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_en = '0; ifa.rd_addr = '0;
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_en = '0; ifb.rd_addr = '0;
    ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.rd_en = '0; ifc.rd_addr = '0;
  endtask

  // One clock of stimulus on DUT d (0=A, 1=B, 2=C, other=none); the others sit idle.
  // e0..e2 are the hand-computed read values for enabled ports.
  task automatic cyc(input int d, input logic we, input int wa, input logic [63:0] wd,
                     input logic [2:0] ren, input int ra0, input int ra1, input int ra2,
                     input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
    exp_t        ex [3];
    logic [63:0] ev [3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    ifa.wr_en = (d == 0) && we; ifa.wr_addr = 5'(wa); ifa.wr_data = wd;
    ifb.wr_en = (d == 1) && we; ifb.wr_addr = 5'(wa); ifb.wr_data = wd;
    ifc.wr_en = (d == 2) && we; ifc.wr_addr = 5'(wa); ifc.wr_data = wd;
    ifa.rd_en = (d == 0) ? ren[1:0] : 2'b00;
    ifb.rd_en = (d == 1) ? ren[1:0] : 2'b00;
    ifc.rd_en = (d == 2) ? ren : 3'b000;
    ifa.rd_addr = {5'(ra1), 5'(ra0)};
    ifb.rd_addr = {5'(ra1), 5'(ra0)};
    ifc.rd_addr = {5'(ra2), 5'(ra1), 5'(ra0)};
    for (int k = 0; k < 3; k++) begin
      ex[k] = '0;
      for (int p = 0; p < 3; p++) begin
        if ((d == k) && ren[p]) hold[k][p] = ev[p];
        ex[k].vld[p] = (d == k) && ren[p];
        ex[k].dat[p] = hold[k][p];
      end
    end
    @(posedge clk);
    #1;
    qa.push_back(ex[0]);
    qb.push_back(ex[1]);
    qc.push_back(ex[2]);
  endtask

  task automatic clear_model();
    qa.delete(); qb.delete(); qc.delete();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 3; p++)
        hold[k][p] = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s A p%0d data", tag, p), ifa.rd_data[p], 64'd0);
      chk($sformatf("%s A p%0d valid", tag, p), 64'(ifa.rd_valid[p]), 64'd0);
      chk($sformatf("%s B p%0d data", tag, p), ifb.rd_data[p], 64'd0);
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s C p%0d data", tag, p), ifc.rd_data[p], 64'd0);
      chk($sformatf("%s C p%0d valid", tag, p), 64'(ifc.rd_valid[p]), 64'd0);
    end
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

  initial begin
    clear_model();
    drive_idle();
    reset_n = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First reads after reset return zero with valid set.
    cyc(0, 0, 0, 64'd0, 3'b011, 0, 5, 0, 64'd0, 64'd0, 64'd0);
    // Write then read the same register on both ports.
    cyc(0, 1, 7, DB, 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b011, 7, 7, 0, DB, DB, 64'd0);
    // Same-cycle bypass on both ports, then the stored value.
    cyc(0, 1, 3, 64'hA5, 3'b011, 3, 3, 0, 64'hA5, 64'hA5, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b011, 3, 7, 0, 64'hA5, DB, 64'd0);
    // Hard-zero register wins over bypass and ignores the write.
    cyc(0, 1, 31, 64'hFFFF, 3'b011, 31, 31, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b001, 31, 0, 0, 64'd0, 64'd0, 64'd0);
    // Without hard-zero, r31 behaves as a normal register.
    cyc(1, 1, 31, 64'hFFFF, 3'b011, 31, 0, 0, 64'hFFFF, 64'd0, 64'd0);
    cyc(1, 0, 0, 64'd0, 3'b001, 31, 0, 0, 64'hFFFF, 64'd0, 64'd0);
    // Hold: rd_data keeps r9's value while rd_en is low, even when r9 is rewritten.
    cyc(0, 1, 9, 64'h11, 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b001, 9, 0, 0, 64'h11, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b000, 1, 4, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 1, 9, 64'h22, 3'b000, 9, 2, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b000, 4, 9, 0, 64'd0, 64'd0, 64'd0);
    // Fill r0..r30 with index*3.
    for (int i = 0; i < 31; i++)
      cyc(0, 1, i, 64'(i * 3), 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    // Write to r6 does not disturb a read of r5; port 1 sees the bypass.
    cyc(0, 1, 6, 64'h77, 3'b011, 5, 6, 0, 64'd15, 64'h77, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b011, 10, 30, 0, 64'd30, 64'd90, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b001, 10, 0, 0, 64'd30, 64'd0, 64'd0);

    // Asynchronous reset pulse between edges clears outputs immediately.
    @(negedge clk);
    #1;
    drive_idle();
    reset_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    clear_model();
    #1;
    reset_n = 1'b1;
    cyc(0, 0, 0, 64'd0, 3'b011, 10, 30, 0, 64'd0, 64'd0, 64'd0);
    cyc(0, 0, 0, 64'd0, 3'b011, 6, 9, 0, 64'd0, 64'd0, 64'd0);

    // DEPTH=24, three ports: out-of-range address 30 reads 0 even with a matching write.
    cyc(2, 1, 23, 64'hCAFE, 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    cyc(2, 1, 30, 64'hBAD, 3'b111, 23, 30, 30, 64'hCAFE, 64'd0, 64'd0);
    cyc(2, 1, 5, 64'h1234, 3'b111, 5, 30, 23, 64'h1234, 64'd0, 64'hCAFE);
    cyc(2, 0, 0, 64'd0, 3'b100, 0, 0, 23, 64'd0, 64'd0, 64'hCAFE);
    cyc(3, 0, 0, 64'd0, 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    cyc(3, 0, 0, 64'd0, 3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0);

    @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
